sram_port_arbiter: RTL and testbench

- Shares one 32-bit x 2048-word on-chip SRAM port between two Avalon-MM requesters (m0, m1).
- Uses weighted round-robin with a bounded hold count.
- Drives the SRAM port's address/byteenable/chipselect/write/writedata/clken and routes the 1-cycle-latency readdata back with readdatavalid.
- Sits between the two system masters and port 1 or port 2 of the dual-port SRAM wrapper.

---
 rtl/sram_port_arbiter_if.sv | 45 ++++
 rtl/sram_port_arbiter.sv | 118 +++++++++++
 tb/tb_sram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundles the two Avalon-MM requester ports and the SRAM port that the
// arbiter sits between. "slave" is the arbiter's view; "master" is the
// system view (the requesters plus the SRAM that returns readdata).
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] m0_address,    m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read,       m1_read;
    logic              m0_write,      m1_write;
    logic [DATA_W-1:0] m0_writedata,  m1_writedata;
    logic              m0_waitrequest,   m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata,      m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;

    logic [ADDR_W-1:0] sram_address;
    logic [BE_W-1:0]   sram_byteenable;
    logic              sram_chipselect;
    logic              sram_write;
    logic [DATA_W-1:0] sram_writedata;
    logic              sram_clken;
    logic [DATA_W-1:0] sram_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output sram_address, sram_byteenable, sram_chipselect,
        output sram_write, sram_writedata, sram_clken,
        input  sram_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  sram_address, sram_byteenable, sram_chipselect,
        input  sram_write, sram_writedata, sram_clken,
        output sram_readdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester weighted round-robin arbiter in front of one single-port
// SRAM port with 1-cycle read latency. A requester keeps the port for up to
// HOLD_MAX consecutive grants while the other one is waiting.
module sram_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.slave   bus
);
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic              req0, req1;
    logic              gnt_valid, gnt_id;
    logic              gnt_rd, gnt_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BE_W-1:0]   cmd_be;
    logic [DATA_W-1:0] cmd_wdata;

    logic              last;
    logic [3:0]        hold_cnt;
    logic              clken_q;
    logic              rd_pend_valid, rd_pend_id;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;

    // Grant decision and command mux. hold_cnt == 0 only occurs straight
    // after reset, where "last" is a seed rather than a real owner, so the
    // first contention goes to ~last (m0). No grants while the SRAM clock
    // enable is still low, since such a command would never be clocked in.
    always_comb begin
        req0   = bus.m0_read | bus.m0_write;
        req1   = bus.m1_read | bus.m1_write;
        gnt_id = 1'b0;
        if (req0 && req1) begin
            if (hold_cnt != 4'd0 && hold_cnt < HOLD_LIM)
                gnt_id = last;
            else
                gnt_id = ~last;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
        gnt_valid = clken_q & (req0 | req1);
        gnt_wr    = gnt_id ? bus.m1_write : bus.m0_write;
        gnt_rd    = (gnt_id ? bus.m1_read : bus.m0_read) & ~gnt_wr;
        cmd_addr  = gnt_id ? bus.m1_address    : bus.m0_address;
        cmd_be    = gnt_id ? bus.m1_byteenable : bus.m0_byteenable;
        cmd_wdata = gnt_id ? bus.m1_writedata  : bus.m0_writedata;
    end

    // Requester-facing and SRAM-facing outputs.
    always_comb begin
        bus.m0_waitrequest   = req0 & ~(gnt_valid & ~gnt_id);
        bus.m1_waitrequest   = req1 & ~(gnt_valid &  gnt_id);
        bus.m0_readdata      = bus.sram_readdata;
        bus.m1_readdata      = bus.sram_readdata;
        bus.m0_readdatavalid = rd_pend_valid & ~rd_pend_id;
        bus.m1_readdatavalid = rd_pend_valid &  rd_pend_id;
        bus.sram_chipselect  = gnt_valid;
        bus.sram_write       = gnt_valid & gnt_wr;
        bus.sram_address     = gnt_valid ? cmd_addr  : addr_q;
        bus.sram_byteenable  = gnt_valid ? cmd_be    : be_q;
        bus.sram_writedata   = gnt_valid ? cmd_wdata : wdata_q;
        bus.sram_clken       = clken_q;
    end

    // Arbitration history: owner of the most recent grant and its run length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= 1'b1;
            hold_cnt <= 4'd0;
        end else if (gnt_valid) begin
            if (gnt_id == last) begin
                if (hold_cnt < HOLD_LIM)
                    hold_cnt <= hold_cnt + 4'd1;
            end else begin
                last     <= gnt_id;
                hold_cnt <= 4'd1;
            end
        end
    end

    // Keep the last granted command so the SRAM pins stay stable when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (gnt_valid) begin
            addr_q  <= cmd_addr;
            be_q    <= cmd_be;
            wdata_q <= cmd_wdata;
        end
    end

    // Read return tag: one entry suffices because latency is exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_valid <= 1'b0;
            rd_pend_id    <= 1'b0;
        end else begin
            rd_pend_valid <= gnt_valid & gnt_rd;
            rd_pend_id    <= gnt_id;
        end
    end

    // SRAM clock enable comes up on the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clken_q <= 1'b0;
        else
            clken_q <= 1'b1;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_strobes = 0;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem     [2048];
    logic [31:0] ref_mem [2048];

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.ADDR_W(11), .DATA_W(32), .BE_W(4), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SRAM model: 1-cycle read latency, byte-lane writes.
    always @(posedge clk) begin
        if (bus.sram_clken && bus.sram_chipselect) begin
            if (bus.sram_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_byteenable[b])
                        mem[bus.sram_address][8*b +: 8] = bus.sram_writedata[8*b +: 8];
            end else begin
                bus.sram_readdata <= mem[bus.sram_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on every strobe; also flag a strobe that is overdue.
    always @(negedge clk) begin
        if (bus.m0_readdatavalid || bus.m1_readdatavalid) begin
            n_strobes++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL sb_unexpected_strobe: observed rdv=%b%b expected none",
                       bus.m1_readdatavalid, bus.m0_readdatavalid);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdv_id", 32'({bus.m1_readdatavalid, bus.m0_readdatavalid}),
                    e.id ? 32'd2 : 32'd1);
                chk("sb_readdata", e.id ? bus.m1_readdata : bus.m0_readdata, e.data);
                chk("sb_latency", 32'(cyc), 32'(e.cyc + 1));
            end
        end else if (sb.size() != 0 && sb[0].cyc + 1 <= cyc) begin
            n_checks++;
            n_errors++;
            $error("FAIL sb_missing_strobe: observed none expected id=%0d data=%h",
                   sb[0].id, sb[0].data);
            void'(sb.pop_front());
        end
    end

    task automatic idle();
        bus.m0_read = 0; bus.m0_write = 0; bus.m0_address = '0;
        bus.m0_byteenable = '0; bus.m0_writedata = '0;
        bus.m1_read = 0; bus.m1_write = 0; bus.m1_address = '0;
        bus.m1_byteenable = '0; bus.m1_writedata = '0;
    endtask

    task automatic drive(input bit id, input bit rd, input bit wr, input logic [10:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (!id) begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
            bus.m0_byteenable = be; bus.m0_writedata = d;
        end else begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
            bus.m1_byteenable = be; bus.m1_writedata = d;
        end
    endtask

    task automatic ref_write(input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // One uncontended command; entered and left at posedge+1.
    task automatic single(input bit id, input bit rd, input bit wr, input logic [10:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        idle();
        drive(id, rd, wr, a, be, d);
        @(negedge clk);
        chk("single_wait", id ? bus.m1_waitrequest : bus.m0_waitrequest, 0);
        chk("single_cs", bus.sram_chipselect, 1);
        chk("single_addr", 32'(bus.sram_address), 32'(a));
        chk("single_wr", bus.sram_write, 32'(wr));
        if (wr) ref_write(a, be, d);
        else if (rd) sb.push_back('{id: id, data: ref_mem[a], cyc: cyc});
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        reset = 1;
        sb.delete();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int p0, p1, ex;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 32'hC0DE_0000 | i;
            ref_mem[i] = 32'hC0DE_0000 | i;
        end
        bus.sram_readdata = '0;
        idle();
        reset = 1;
        #1;
        @(negedge clk);
        chk("rst_cs", bus.sram_chipselect, 0);
        chk("rst_write", bus.sram_write, 0);
        chk("rst_clken", bus.sram_clken, 0);
        chk("rst_addr", 32'(bus.sram_address), 0);
        chk("rst_rdv", 32'({bus.m1_readdatavalid, bus.m0_readdatavalid}), 0);
        reset = 0;
        #1;
        chk("rel_clken_low", bus.sram_clken, 0);
        @(posedge clk); #1;
        chk("rel_clken_high", bus.sram_clken, 1);

        // m0 single read of 0x005
        single(0, 1, 0, 11'h005, 4'hF, 0);
        @(negedge clk);
        chk("rd5_m0_rdv", bus.m0_readdatavalid, 1);
        chk("rd5_m1_rdv", bus.m1_readdatavalid, 0);
        @(posedge clk); #1;

        // Continuous contention after a fresh reset: m0 x4, m1 x4, m0 x4
        do_reset();
        p0 = 0; p1 = 0;
        for (int k = 0; k < 12; k++) begin
            drive(0, 0, 1, 11'(11'h010 + p0), 4'hF, 32'hA000_0000 + p0);
            drive(1, 0, 1, 11'(11'h400 + p1), 4'hF, 32'hB000_0000 + p1);
            @(negedge clk);
            ex = (k / 4) % 2;
            chk("wrr_m0_wait", bus.m0_waitrequest, 32'(ex == 1));
            chk("wrr_m1_wait", bus.m1_waitrequest, 32'(ex == 0));
            if (ex == 0) begin
                chk("wrr_addr", 32'(bus.sram_address), 32'h010 + p0);
                chk("wrr_wdata", bus.sram_writedata, 32'hA000_0000 + p0);
                ref_write(11'(11'h010 + p0), 4'hF, 32'hA000_0000 + p0);
                p0++;
            end else begin
                chk("wrr_addr", 32'(bus.sram_address), 32'h400 + p1);
                chk("wrr_wdata", bus.sram_writedata, 32'hB000_0000 + p1);
                ref_write(11'(11'h400 + p1), 4'hF, 32'hB000_0000 + p1);
                p1++;
            end
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        chk("idle_cs", bus.sram_chipselect, 0);
        chk("idle_addr_hold", 32'(bus.sram_address), 32'h017);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) single(0, 1, 0, 11'(11'h010 + i), 4'hF, 0);
        for (int i = 0; i < 5; i++) single(1, 1, 0, 11'(11'h400 + i), 4'hF, 0);

        // Write by m0 then read by m1, full and partial byteenable
        single(0, 0, 1, 11'h123, 4'hF, 32'hDEADBEEF);
        single(1, 1, 0, 11'h123, 4'hF, 0);
        single(0, 0, 1, 11'h123, 4'h3, 32'h0000AAAA);
        single(1, 1, 0, 11'h123, 4'hF, 0);
        chk("merge_ref", ref_mem[11'h123], 32'hDEADAAAA);

        // Alternating back-to-back reads
        @(posedge clk); #1;
        ex = n_strobes;
        for (int i = 0; i < 8; i++) single(1'(i % 2), 1, 0, 11'(11'h200 + i), 4'hF, 0);
        @(posedge clk); #1;
        chk("alt_strobes", 32'(n_strobes - ex), 8);

        // Read+write together is a write
        single(0, 1, 1, 11'h7FF, 4'hF, 32'h12345678);
        @(negedge clk);
        chk("rw_no_rdv", bus.m0_readdatavalid, 0);
        @(posedge clk); #1;
        single(1, 1, 0, 11'h7FF, 4'hF, 0);
        @(posedge clk); #1;

        // Reset in the cycle after an m1 read issue drops the return
        idle();
        drive(1, 1, 0, 11'h030, 4'hF, 0);
        @(negedge clk);
        chk("rstrd_issue", bus.m1_waitrequest, 0);
        @(posedge clk); #1;
        idle();
        reset = 1;
        sb.delete();
        @(negedge clk);
        chk("rstrd_no_rdv", bus.m1_readdatavalid, 0);
        chk("rstrd_clken", bus.sram_clken, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rstrd_clken_low", bus.sram_clken, 0);
        chk("rstrd_no_rdv2", bus.m1_readdatavalid, 0);
        @(posedge clk); #1;
        chk("rstrd_clken_high", bus.sram_clken, 1);
        drive(0, 1, 0, 11'h040, 4'hF, 0);
        drive(1, 1, 0, 11'h041, 4'hF, 0);
        @(negedge clk);
        chk("first_m0_wait", bus.m0_waitrequest, 0);
        chk("first_m1_wait", bus.m1_waitrequest, 1);
        chk("first_addr", 32'(bus.sram_address), 32'h040);
        sb.push_back('{id: 1'b0, data: ref_mem[11'h040], cyc: cyc});
        @(posedge clk); #1;
        drive(0, 0, 0, 11'h000, 4'h0, 0);
        @(negedge clk);
        chk("second_m1_wait", bus.m1_waitrequest, 0);
        chk("second_addr", 32'(bus.sram_address), 32'h041);
        sb.push_back('{id: 1'b1, data: ref_mem[11'h041], cyc: cyc});
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
